// File: rtl/generic_bus_arbiter_if.sv
// Generic-bus bundle between two requesters, the arbiter and the shared ram port.
// "slave" is the arbiter's view; "master" is the surrounding system's view.
interface generic_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] m0_addr;
  logic              m0_ren;
  logic              m0_wen;
  logic [DATA_W-1:0] m0_wdata;
  logic [BE_W-1:0]   m0_byte_en;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_busy;

  logic [ADDR_W-1:0] m1_addr;
  logic              m1_ren;
  logic              m1_wen;
  logic [DATA_W-1:0] m1_wdata;
  logic [BE_W-1:0]   m1_byte_en;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_busy;

  logic [ADDR_W-1:0] s_addr;
  logic              s_ren;
  logic              s_wen;
  logic [DATA_W-1:0] s_wdata;
  logic [BE_W-1:0]   s_byte_en;
  logic [DATA_W-1:0] s_rdata;
  logic              s_busy;

  modport slave (
    input  m0_addr, m0_ren, m0_wen, m0_wdata, m0_byte_en,
    output m0_rdata, m0_busy,
    input  m1_addr, m1_ren, m1_wen, m1_wdata, m1_byte_en,
    output m1_rdata, m1_busy,
    output s_addr, s_ren, s_wen, s_wdata, s_byte_en,
    input  s_rdata, s_busy
  );

  modport master (
    output m0_addr, m0_ren, m0_wen, m0_wdata, m0_byte_en,
    input  m0_rdata, m0_busy,
    output m1_addr, m1_ren, m1_wen, m1_wdata, m1_byte_en,
    input  m1_rdata, m1_busy,
    input  s_addr, s_ren, s_wen, s_wdata, s_byte_en,
    output s_rdata, s_busy
  );
endinterface

// File: rtl/generic_bus_arbiter.sv
// Two-master, one-slave generic-bus arbiter: one transfer per grant, round-robin
// or fixed priority, with per-master completed-transfer counters.
module generic_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int CNT_W          = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  generic_bus_arbiter_if.slave bus,
  output logic [1:0]           grant,
  output logic [CNT_W-1:0]     m0_xfer_cnt,
  output logic [CNT_W-1:0]     m1_xfer_cnt
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic [1:0]       grant_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic req0, req1, pick1_d;

  always_comb begin
    req0 = bus.m0_ren | bus.m0_wen;
    req1 = bus.m1_ren | bus.m1_wen;
    // last_grant_q=1 means M1 won last, so a round-robin tie goes to M0.
    if (FIXED_PRIORITY != 0) pick1_d = req1 & ~req0;
    else                     pick1_d = req1 & (~req0 | ~last_grant_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick1_d) begin
            state_q <= GNT1;
            grant_q <= 2'b10;
          end else if (req0) begin
            state_q <= GNT0;
            grant_q <= 2'b01;
          end
        end
        GNT0: begin
          if (!req0) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end else if (!bus.s_busy) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b0;
            cnt0_q       <= cnt0_q + CNT_W'(1);
          end
        end
        GNT1: begin
          if (!req1) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end else if (!bus.s_busy) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            cnt1_q       <= cnt1_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic [BE_W-1:0]   be_mux;
  logic              ren_mux, wen_mux;

  // Slave side follows the owner combinationally; an idle bus is driven all-zero.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    be_mux    = '0;
    ren_mux   = 1'b0;
    wen_mux   = 1'b0;
    if (grant_q[0]) begin
      addr_mux  = bus.m0_addr;
      wdata_mux = bus.m0_wdata;
      be_mux    = bus.m0_byte_en;
      ren_mux   = bus.m0_ren;
      wen_mux   = bus.m0_wen;
    end else if (grant_q[1]) begin
      addr_mux  = bus.m1_addr;
      wdata_mux = bus.m1_wdata;
      be_mux    = bus.m1_byte_en;
      ren_mux   = bus.m1_ren;
      wen_mux   = bus.m1_wen;
    end
  end

  assign bus.s_addr    = addr_mux;
  assign bus.s_wdata   = wdata_mux;
  assign bus.s_byte_en = be_mux;
  assign bus.s_ren     = ren_mux;
  assign bus.s_wen     = wen_mux;

  assign bus.m0_busy  = grant_q[0] ? bus.s_busy : 1'b1;
  assign bus.m1_busy  = grant_q[1] ? bus.s_busy : 1'b1;
  assign bus.m0_rdata = bus.s_rdata;
  assign bus.m1_rdata = bus.s_rdata;

  assign grant       = grant_q;
  assign m0_xfer_cnt = cnt0_q;
  assign m1_xfer_cnt = cnt1_q;
endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Directed bench for generic_bus_arbiter: a round-robin instance and a
// fixed-priority instance with 4-bit counters share identical stimulus.
module tb_generic_bus_arbiter;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ren, m0_wen, m1_ren, m1_wen, s_busy;

  generic_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_rr ();
  generic_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_fp ();

  assign bus_rr.m0_addr = m0_addr;    assign bus_fp.m0_addr = m0_addr;
  assign bus_rr.m0_ren = m0_ren;      assign bus_fp.m0_ren = m0_ren;
  assign bus_rr.m0_wen = m0_wen;      assign bus_fp.m0_wen = m0_wen;
  assign bus_rr.m0_wdata = m0_wdata;  assign bus_fp.m0_wdata = m0_wdata;
  assign bus_rr.m0_byte_en = m0_be;   assign bus_fp.m0_byte_en = m0_be;
  assign bus_rr.m1_addr = m1_addr;    assign bus_fp.m1_addr = m1_addr;
  assign bus_rr.m1_ren = m1_ren;      assign bus_fp.m1_ren = m1_ren;
  assign bus_rr.m1_wen = m1_wen;      assign bus_fp.m1_wen = m1_wen;
  assign bus_rr.m1_wdata = m1_wdata;  assign bus_fp.m1_wdata = m1_wdata;
  assign bus_rr.m1_byte_en = m1_be;   assign bus_fp.m1_byte_en = m1_be;
  assign bus_rr.s_rdata = s_rdata;    assign bus_fp.s_rdata = s_rdata;
  assign bus_rr.s_busy = s_busy;      assign bus_fp.s_busy = s_busy;

  logic [1:0]  g_rr, g_fp;
  logic [31:0] rr_c0, rr_c1;
  logic [3:0]  fp_c0, fp_c1;

  generic_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIORITY(0), .CNT_W(32)) u_rr (
    .CLK(CLK), .RST(RST), .bus(bus_rr), .grant(g_rr),
    .m0_xfer_cnt(rr_c0), .m1_xfer_cnt(rr_c1));

  generic_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIORITY(1), .CNT_W(4)) u_fp (
    .CLK(CLK), .RST(RST), .bus(bus_fp), .grant(g_fp),
    .m0_xfer_cnt(fp_c0), .m1_xfer_cnt(fp_c1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven there.
  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    m0_ren = 0; m0_wen = 0; m1_ren = 0; m1_wen = 0; s_busy = 0; s_rdata = '0;
    next();
    next();
    RST = 1'b0;
  endtask

  typedef struct {
    logic        rst, r0, w0, r1, w1, sb, chk;
    logic [31:0] srd;
    logic [1:0]  g_rr, g_fp;
    logic        m0b, m1b;
    logic [31:0] c0, c1, rd;
  } vec_t;

  vec_t v [14];

  initial begin
    RST = 1'b0;
    m0_addr = 32'h100;  m0_wdata = 32'hAAAA_AAAA; m0_be = 4'hF;
    m1_addr = 32'h1F00; m1_wdata = 32'h1234_5678; m1_be = 4'b0011;
    next();
    do_reset();

    // Reset state
    #1;
    chk("rst_grant_rr", g_rr, 2'b00);
    chk("rst_m0_busy", bus_rr.m0_busy, 1'b1);
    chk("rst_m1_busy", bus_rr.m1_busy, 1'b1);
    chk("rst_s_ren", bus_rr.s_ren, 1'b0);
    chk("rst_cnt0", rr_c0, 0);
    chk("rst_cnt1", rr_c1, 0);

    //        rst r0 w0 r1 w1 sb chk srd           g_rr   g_fp   m0b m1b c0 c1 rd
    // single read with one wait state
    v[0]  = '{0, 1, 0, 0, 0, 0, 1, 32'h0,         2'b00, 2'b00, 1, 1, 0, 0, 0};
    v[1]  = '{0, 1, 0, 0, 0, 1, 1, 32'h0,         2'b01, 2'b01, 1, 1, 0, 0, 0};
    v[2]  = '{0, 1, 0, 0, 0, 0, 1, 32'hDEADBEEF,  2'b01, 2'b01, 0, 1, 0, 0, 32'hDEADBEEF};
    v[3]  = '{0, 0, 0, 0, 0, 0, 1, 32'h0,         2'b00, 2'b00, 1, 1, 1, 0, 0};
    v[4]  = '{1, 0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 2'b00, 1, 1, 0, 0, 0};
    // tie: m0 read + m1 write, zero-wait slave
    v[5]  = '{0, 1, 0, 0, 1, 0, 1, 32'h0,         2'b00, 2'b00, 1, 1, 0, 0, 0};
    v[6]  = '{0, 1, 0, 0, 1, 0, 1, 32'h11,        2'b01, 2'b01, 0, 1, 0, 0, 32'h11};
    v[7]  = '{0, 1, 0, 0, 1, 0, 1, 32'h0,         2'b00, 2'b00, 1, 1, 1, 0, 0};
    v[8]  = '{0, 1, 0, 0, 1, 0, 1, 32'h0,         2'b10, 2'b01, 1, 0, 1, 0, 0};
    v[9]  = '{0, 1, 0, 0, 1, 0, 1, 32'h0,         2'b00, 2'b00, 1, 1, 1, 1, 0};
    v[10] = '{0, 1, 0, 0, 1, 0, 1, 32'h22,        2'b01, 2'b01, 0, 1, 1, 1, 32'h22};
    v[11] = '{0, 1, 0, 0, 1, 0, 1, 32'h0,         2'b00, 2'b00, 1, 1, 2, 1, 0};
    v[12] = '{0, 1, 0, 0, 1, 0, 1, 32'h0,         2'b10, 2'b01, 1, 0, 2, 1, 0};
    v[13] = '{0, 0, 0, 0, 0, 0, 1, 32'h0,         2'b00, 2'b00, 1, 1, 2, 2, 0};

    for (int i = 0; i < 14; i++) begin
      RST = v[i].rst; m0_ren = v[i].r0; m0_wen = v[i].w0;
      m1_ren = v[i].r1; m1_wen = v[i].w1; s_busy = v[i].sb; s_rdata = v[i].srd;
      #1;
      if (v[i].chk) begin
        chk($sformatf("v%0d_grant_rr", i), g_rr, v[i].g_rr);
        chk($sformatf("v%0d_grant_fp", i), g_fp, v[i].g_fp);
        chk($sformatf("v%0d_m0_busy", i), bus_rr.m0_busy, v[i].m0b);
        chk($sformatf("v%0d_m1_busy", i), bus_rr.m1_busy, v[i].m1b);
        chk($sformatf("v%0d_fp_m1_busy", i), bus_fp.m1_busy, 1'b1);
        chk($sformatf("v%0d_cnt0", i), rr_c0, v[i].c0);
        chk($sformatf("v%0d_cnt1", i), rr_c1, v[i].c1);
        if (!v[i].m0b) chk($sformatf("v%0d_m0_rdata", i), bus_rr.m0_rdata, v[i].rd);
      end
      next();
    end
    chk("fp_tie_cnt0", fp_c0, 4'd4);
    chk("fp_tie_cnt1", fp_c1, 4'd0);

    // Write forwarding from M1
    m1_wen = 1; s_busy = 1;
    #1;
    chk("wr_idle_s_wen", bus_rr.s_wen, 1'b0);
    chk("wr_idle_s_addr", bus_rr.s_addr, 32'h0);
    chk("wr_idle_s_be", bus_rr.s_byte_en, 4'h0);
    next();
    #1;
    chk("wr_grant", g_rr, 2'b10);
    chk("wr_s_wen", bus_rr.s_wen, 1'b1);
    chk("wr_s_ren", bus_rr.s_ren, 1'b0);
    chk("wr_s_addr", bus_rr.s_addr, 32'h1F00);
    chk("wr_s_wdata", bus_rr.s_wdata, 32'h1234_5678);
    chk("wr_s_be", bus_rr.s_byte_en, 4'b0011);
    chk("wr_m0_busy", bus_rr.m0_busy, 1'b1);
    chk("wr_m1_busy_wait", bus_rr.m1_busy, 1'b1);
    next();
    s_busy = 0;
    #1;
    chk("wr_m1_busy_done", bus_rr.m1_busy, 1'b0);
    chk("wr_m0_busy_done", bus_rr.m0_busy, 1'b1);
    next();
    m1_wen = 0;
    #1;
    chk("wr_after_grant", g_rr, 2'b00);
    chk("wr_after_s_wen", bus_rr.s_wen, 1'b0);
    chk("wr_after_s_wdata", bus_rr.s_wdata, 32'h0);
    chk("wr_after_cnt1", rr_c1, 3);

    // Abort: drop m0_ren while granted
    m0_ren = 1; s_busy = 1;
    next();
    #1;
    chk("ab_grant", g_rr, 2'b01);
    next();
    m0_ren = 0; s_busy = 0;
    #1;
    chk("ab_still_gnt", g_rr, 2'b01);
    next();
    #1;
    chk("ab_idle", g_rr, 2'b00);
    chk("ab_cnt0", rr_c0, 2);
    // last grant remains M1, so a tie goes to M0
    m0_ren = 1; m1_wen = 1;
    next();
    #1;
    chk("ab_tie_grant", g_rr, 2'b01);
    next();
    m0_ren = 0; m1_wen = 0;
    next();

    // Counter wrap: 16 zero-wait M0 completions
    do_reset();
    m0_ren = 1; s_busy = 0;
    for (int i = 0; i < 32; i++) next();
    m0_ren = 0;
    #1;
    chk("wrap_rr_cnt0", rr_c0, 16);
    chk("wrap_fp_cnt0", fp_c0, 4'd0);
    chk("wrap_grant", g_rr, 2'b00);
    next();

    // Reset mid-transfer
    m0_ren = 1; s_busy = 1;
    next();
    #1;
    chk("mr_grant", g_rr, 2'b01);
    RST = 1;
    next();
    RST = 0; m1_wen = 1;
    #1;
    chk("mr_idle_grant", g_rr, 2'b00);
    chk("mr_s_ren", bus_rr.s_ren, 1'b0);
    chk("mr_cnt0", rr_c0, 0);
    chk("mr_cnt1", rr_c1, 0);
    chk("mr_m0_busy", bus_rr.m0_busy, 1'b1);
    next();
    #1;
    chk("mr_tie_grant", g_rr, 2'b01);
    m0_ren = 0; m1_wen = 0;
    next();
    next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
